// File: rtl/bullet_spawn_controller_pkg.sv
// Shared types for the bullet spawn controller: FSM state codes,
// spawn queue entry layout and queue depth.
package bullet_spawn_controller_pkg;

   localparam int SPQ_DEPTH = 4;
   localparam int SPQ_AW    = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_READY   = 2'd1;
   localparam state_t ST_SPACING = 2'd2;
   localparam state_t ST_LOCKOUT = 2'd3;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
   } spawn_t;

endpackage

// File: rtl/bullet_spawn_controller_spawn_fifo.sv
// Four-entry first-word-fall-through queue of pending bullet spawns.
// Flush empties the queue and takes priority over push and pop.
module spawn_fifo
   import bullet_spawn_controller_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   flush,
   input  logic   push,
   input  logic   pop,
   input  spawn_t din,
   output spawn_t dout,
   output logic   full,
   output logic   empty
);

   spawn_t            mem [SPQ_DEPTH];
   logic [SPQ_AW-1:0] wr_ptr;
   logic [SPQ_AW-1:0] rd_ptr;
   logic [SPQ_AW:0]   count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (SPQ_AW+1)'(SPQ_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < SPQ_DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bullet_spawn_controller.sv
// Fire control: rate-limits shots, locks out on gun heat, queues spawns.
// OVERHEAT_HYSTERESIS_EN: lockout releases at heat <= COOL_THRESH.
module bullet_spawn_controller
   import bullet_spawn_controller_pkg::*;
#(
   parameter int unsigned SHOT_PERIOD = 12500000,
   parameter logic [3:0]  HOT_THRESH  = 4'd12,
   parameter logic [3:0]  COOL_THRESH = 4'd6,
   parameter logic [6:0]  Y_OFFSET    = 7'd4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       startGameEn,
   input  logic       shoot,
   input  logic [3:0] heat,
   input  logic [7:0] ship_x,
   input  logic [6:0] ship_y,
   input  logic       spawn_ready,
   output logic       spawn_valid,
   output logic [7:0] spawn_x,
   output logic [6:0] spawn_y,
   output logic       overheated,
   output logic [7:0] shots_fired
);

   localparam int CW = $clog2(SHOT_PERIOD + 1);
   localparam logic [CW-1:0] SPACE_LOAD = CW'(SHOT_PERIOD - 1);

   state_t        state;
   logic [CW-1:0] space_cnt;
   logic          too_hot;
   logic          release_lock;
   logic          q_full;
   logic          q_empty;
   logic          accept;
   spawn_t        new_entry;
   spawn_t        head;

`ifdef OVERHEAT_HYSTERESIS_EN
   assign release_lock = (heat <= COOL_THRESH);
`else
   logic unused_cool;
   assign unused_cool  = ^COOL_THRESH;
   assign release_lock = (heat < HOT_THRESH);
`endif

   assign too_hot = (heat >= HOT_THRESH);
   // heat refusal wins over a full queue
   assign accept  = (state == ST_READY) & shoot & ~too_hot
                  & ~q_full & ~startGameEn;

   assign new_entry.x = ship_x;
   assign new_entry.y = (ship_y < Y_OFFSET) ? 7'd0 : ship_y - Y_OFFSET;

   spawn_fifo u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (startGameEn),
      .push  (accept),
      .pop   (spawn_ready),
      .din   (new_entry),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty)
   );

   assign spawn_valid = ~q_empty;
   assign spawn_x     = head.x;
   assign spawn_y     = head.y;
   assign overheated  = (state == ST_LOCKOUT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         space_cnt   <= '0;
         shots_fired <= '0;
      end else if (startGameEn) begin
         state       <= ST_READY;
         space_cnt   <= '0;
         shots_fired <= '0;
      end else begin
         case (state)
            ST_READY: begin
               if (shoot && too_hot) begin
                  state <= ST_LOCKOUT;
               end else if (accept) begin
                  state     <= ST_SPACING;
                  space_cnt <= SPACE_LOAD;
                  if (shots_fired != 8'hFF)
                     shots_fired <= shots_fired + 8'd1;
               end
            end
            ST_SPACING: begin
               if (space_cnt == '0)
                  state <= ST_READY;
               else
                  space_cnt <= space_cnt - 1'b1;
            end
            ST_LOCKOUT: begin
               if (release_lock)
                  state <= ST_READY;
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_spawn_controller.sv
// Directed bench for bullet_spawn_controller with a spawn scoreboard.
// Expected spawns are queued when a shot should be accepted.
module tb_bullet_spawn_controller;
   import bullet_spawn_controller_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       startGameEn = 1'b0;
   logic       shoot = 1'b0;
   logic [3:0] heat = 4'd0;
   logic [7:0] ship_x = 8'd0;
   logic [6:0] ship_y = 7'd0;
   logic       spawn_ready = 1'b0;
   logic       spawn_valid;
   logic [7:0] spawn_x;
   logic [6:0] spawn_y;
   logic       overheated;
   logic [7:0] shots_fired;

   int     total = 0;
   int     passed = 0;
   spawn_t sb [$];
   spawn_t exp_e;

   bullet_spawn_controller #(.SHOT_PERIOD(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .startGameEn (startGameEn),
      .shoot       (shoot),
      .heat        (heat),
      .ship_x      (ship_x),
      .ship_y      (ship_y),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .spawn_x     (spawn_x),
      .spawn_y     (spawn_y),
      .overheated  (overheated),
      .shots_fired (shots_fired)
   );

   always #10 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic start_pulse();
      startGameEn = 1'b1;
      sb.delete();
      tick();
      startGameEn = 1'b0;
   endtask

   task automatic exp_push(input logic [7:0] x, input logic [6:0] y);
      exp_e.x = x;
      exp_e.y = y;
      sb.push_back(exp_e);
   endtask

   // handshake seen here completes at the next rising edge
   always @(negedge clock) begin
      if (!reset && !startGameEn && spawn_valid && spawn_ready) begin
         if (sb.size() == 0) begin
            chk("spawn_expected", 32'(sb.size()), 32'd1);
         end else begin
            exp_e = sb.pop_front();
            chk("spawn_x", 32'(spawn_x), 32'(exp_e.x));
            chk("spawn_y", 32'(spawn_y), 32'(exp_e.y));
         end
      end
   end

   initial begin
      tick(2);
      chk("rst_valid", 32'(spawn_valid), 32'd0);
      chk("rst_x", 32'(spawn_x), 32'd0);
      chk("rst_y", 32'(spawn_y), 32'd0);
      chk("rst_oh", 32'(overheated), 32'd0);
      chk("rst_shots", 32'(shots_fired), 32'd0);

      reset = 1'b0;
      shoot = 1'b1;
      heat  = 4'd3;
      tick(3);
      chk("idle_shots", 32'(shots_fired), 32'd0);
      chk("idle_valid", 32'(spawn_valid), 32'd0);
      shoot = 1'b0;

      start_pulse();
      ship_x      = 8'd40;
      ship_y      = 7'd50;
      spawn_ready = 1'b1;
      shoot       = 1'b1;
      exp_push(8'd40, 7'd46);
      tick();
      chk("t1_valid", 32'(spawn_valid), 32'd1);
      chk("t1_x", 32'(spawn_x), 32'd40);
      chk("t1_y", 32'(spawn_y), 32'd46);
      chk("t1_shots", 32'(shots_fired), 32'd1);
      tick(8);
      chk("gap_shots", 32'(shots_fired), 32'd1);
      chk("gap_valid", 32'(spawn_valid), 32'd0);
      exp_push(8'd40, 7'd46);
      tick();
      chk("t2_shots", 32'(shots_fired), 32'd2);
      chk("t2_valid", 32'(spawn_valid), 32'd1);
      shoot = 1'b0;
      tick(10);
      chk("t2_drained", 32'(sb.size()), 32'd0);

      heat  = 4'd12;
      shoot = 1'b1;
      tick();
      chk("lock_oh", 32'(overheated), 32'd1);
      chk("lock_valid", 32'(spawn_valid), 32'd0);
      chk("lock_shots", 32'(shots_fired), 32'd2);
      shoot = 1'b0;
`ifdef OVERHEAT_HYSTERESIS_EN
      heat = 4'd11;
      tick();
      chk("hys_11", 32'(overheated), 32'd1);
      heat = 4'd7;
      tick();
      chk("hys_7", 32'(overheated), 32'd1);
      heat = 4'd6;
      tick();
      chk("hys_6", 32'(overheated), 32'd0);
`else
      heat = 4'd12;
      tick();
      chk("lock_12", 32'(overheated), 32'd1);
      heat = 4'd11;
      tick();
      chk("lock_11", 32'(overheated), 32'd0);
`endif

      heat        = 4'd0;
      spawn_ready = 1'b0;
      start_pulse();
      ship_y = 7'd20;
      shoot  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ship_x = 8'(10 + i);
         exp_push(8'(10 + i), 7'd16);
         tick(9);
      end
      chk("full_shots", 32'(shots_fired), 32'd4);
      chk("full_valid", 32'(spawn_valid), 32'd1);
      chk("full_head_x", 32'(spawn_x), 32'd10);
      ship_x = 8'd99;
      tick(12);
      chk("refuse_shots", 32'(shots_fired), 32'd4);
      chk("hold_x", 32'(spawn_x), 32'd10);
      chk("hold_y", 32'(spawn_y), 32'd16);
      shoot       = 1'b0;
      spawn_ready = 1'b1;
      tick(6);
      chk("full_drained", 32'(sb.size()), 32'd0);
      chk("full_empty", 32'(spawn_valid), 32'd0);

      ship_x = 8'd7;
      ship_y = 7'd2;
      shoot  = 1'b1;
      exp_push(8'd7, 7'd0);
      tick();
      chk("sat_y", 32'(spawn_y), 32'd0);
      chk("sat_x", 32'(spawn_x), 32'd7);
      shoot = 1'b0;
      tick(10);

      start_pulse();
      ship_x = 8'd5;
      ship_y = 7'd30;
      shoot  = 1'b1;
      for (int i = 0; i < 260; i++) begin
         exp_push(8'd5, 7'd26);
         tick(9);
      end
      chk("sat_shots", 32'(shots_fired), 32'd255);
      shoot = 1'b0;
      tick(3);
      chk("sat_drained", 32'(sb.size()), 32'd0);

      start_pulse();
      spawn_ready = 1'b0;
      ship_x      = 8'd60;
      ship_y      = 7'd60;
      shoot       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_push(8'd60, 7'd56);
         tick(i == 2 ? 3 : 9);
      end
      chk("pre_rst_valid", 32'(spawn_valid), 32'd1);
      reset = 1'b1;
      sb.delete();
      #1;
      chk("async_valid", 32'(spawn_valid), 32'd0);
      chk("async_x", 32'(spawn_x), 32'd0);
      chk("async_shots", 32'(shots_fired), 32'd0);
      tick();
      reset = 1'b0;
      tick(12);
      chk("post_rst_valid", 32'(spawn_valid), 32'd0);
      chk("post_rst_shots", 32'(shots_fired), 32'd0);

      start_pulse();
      for (int i = 0; i < 2; i++) begin
         exp_push(8'd60, 7'd56);
         tick(9);
      end
      chk("pre_flush_shots", 32'(shots_fired), 32'd2);
      shoot = 1'b0;
      start_pulse();
      chk("flush_valid", 32'(spawn_valid), 32'd0);
      chk("flush_shots", 32'(shots_fired), 32'd0);
      shoot = 1'b1;
      exp_push(8'd60, 7'd56);
      tick();
      chk("flush_ready_shots", 32'(shots_fired), 32'd1);
      chk("flush_ready_valid", 32'(spawn_valid), 32'd1);
      shoot       = 1'b0;
      spawn_ready = 1'b1;
      tick(3);
      chk("final_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
